tse_pcs_ctrl: RTL and testbench

Control-port sequencer for one TSE PCS channel in `eth_phy`. After the transceiver reset controller reports TX and RX ready, it writes the PCS configuration registers over the Avalon-MM control port. It then polls link and autonegotiation status and reads the link-partner ability. It restarts autonegotiation when the link fails to come up or drops, and publishes link status to the system side. One instance per SFP channel, clocked by the control-port clock.

---
 rtl/tse_pcs_pkg.sv | 29 ++
 rtl/tse_reg_access.sv | 46 ++++
 rtl/tse_pcs_ctrl.sv | 140 ++++++++++++++
 tb/tb_tse_pcs_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tse_pcs_pkg.sv
// tse_pcs_pkg: PCS register map, status bit positions and sequencer states
// shared by the TSE PCS control-port sequencer.
package tse_pcs_pkg;

   localparam logic [4:0] PCS_CONTROL         = 5'h00;
   localparam logic [4:0] PCS_STATUS          = 5'h01;
   localparam logic [4:0] PCS_DEV_ABILITY     = 5'h04;
   localparam logic [4:0] PCS_PARTNER_ABILITY = 5'h05;
   localparam logic [4:0] PCS_LINK_TIMER_LO   = 5'h12;
   localparam logic [4:0] PCS_LINK_TIMER_HI   = 5'h13;
   localparam logic [4:0] PCS_IF_MODE         = 5'h14;

   localparam int STAT_LINK    = 2;
   localparam int STAT_AN_DONE = 5;

   localparam logic [15:0] CTRL_AN_RESTART = 16'h1340;

   localparam logic [2:0] CFG_LAST = 3'd4;

   typedef enum logic [2:0] {
      WAIT_PHY,
      CFG,
      POLL_WAIT,
      STAT_RD,
      PART_RD,
      RESTART
   } state_t;

endpackage

// File: rtl/tse_reg_access.sv
// tse_reg_access: single-access Avalon-MM master; registers one request and holds
// address, data and strobe until waitrequest drops, then frees the port.
module tse_reg_access
   import tse_pcs_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [4:0]  addr,
   input  logic [15:0] wdata,
   output logic        done,
   output logic        active,
   output logic [15:0] rdata,
   output logic [4:0]  reg_addr,
   output logic        reg_rd,
   output logic        reg_wr,
   output logic [15:0] reg_data_in,
   input  logic [15:0] reg_data_out,
   input  logic        reg_busy
);

   assign active = reg_rd | reg_wr;
   assign done   = active & ~reg_busy;
   assign rdata  = reg_data_out;

   // A request is only accepted while idle, so the cycle after a completion is
   // always strobe-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_rd      <= 1'b0;
         reg_wr      <= 1'b0;
         reg_addr    <= '0;
         reg_data_in <= '0;
      end else if (done) begin
         reg_rd <= 1'b0;
         reg_wr <= 1'b0;
      end else if (!active && req) begin
         reg_rd      <= ~wr;
         reg_wr      <= wr;
         reg_addr    <= addr;
         reg_data_in <= wdata;
      end
   end

endmodule

// File: rtl/tse_pcs_ctrl.sv
// tse_pcs_ctrl: configures one TSE PCS channel after PHY ready, then polls link/AN
// status, reads partner ability on link-up and restarts AN on timeout or request.
module tse_pcs_ctrl
   import tse_pcs_pkg::*;
#(
   parameter logic [15:0] IF_MODE      = 16'h0000,
   parameter logic [15:0] DEV_ABILITY  = 16'h01A0,
   parameter logic [20:0] LINK_TIMER   = 21'h1312D0,
   parameter int          POLL_PERIOD  = 50_000,
   parameter int          LINK_TIMEOUT = 25_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        phy_ready,
   input  logic        an_restart_req,
   output logic [4:0]  reg_addr,
   output logic        reg_rd,
   output logic        reg_wr,
   output logic [15:0] reg_data_in,
   input  logic [15:0] reg_data_out,
   input  logic        reg_busy,
   output logic        cfg_done,
   output logic        link_up,
   output logic [15:0] partner_ability,
   output logic [7:0]  restart_cnt
);

   localparam int PW = $clog2(POLL_PERIOD);
   localparam int LW = $clog2(LINK_TIMEOUT);
   localparam logic [PW-1:0] POLL_MAX = PW'(POLL_PERIOD - 1);
   localparam logic [LW-1:0] LD_MAX   = LW'(LINK_TIMEOUT - 1);

   state_t        state, next;
   logic [2:0]    idx;
   logic [PW-1:0] poll_cnt;
   logic [LW-1:0] ld_cnt;
   logic          pend, req, wr, done, active, stat_link, drop, timeout;
   logic          cfg_end, rs_done, rs_enter;
   logic [4:0]    addr, cfg_addr;
   logic [15:0]   wdata, cfg_data, rdata;

   tse_reg_access u_acc (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .wr           (wr),
      .addr         (addr),
      .wdata        (wdata),
      .done         (done),
      .active       (active),
      .rdata        (rdata),
      .reg_addr     (reg_addr),
      .reg_rd       (reg_rd),
      .reg_wr       (reg_wr),
      .reg_data_in  (reg_data_in),
      .reg_data_out (reg_data_out),
      .reg_busy     (reg_busy)
   );

   always_comb begin
      cfg_addr  = idx == 3'd0 ? PCS_IF_MODE :
                  idx == 3'd1 ? PCS_DEV_ABILITY :
                  idx == 3'd2 ? PCS_LINK_TIMER_LO :
                  idx == 3'd3 ? PCS_LINK_TIMER_HI : PCS_CONTROL;
      cfg_data  = idx == 3'd0 ? IF_MODE :
                  idx == 3'd1 ? DEV_ABILITY :
                  idx == 3'd2 ? LINK_TIMER[15:0] :
                  idx == 3'd3 ? {11'b0, LINK_TIMER[20:16]} : CTRL_AN_RESTART;
      req       = phy_ready & (state == CFG || state == STAT_RD || state == PART_RD || state == RESTART);
      wr        = state == CFG || state == RESTART;
      addr      = state == CFG ? cfg_addr : state == STAT_RD ? PCS_STATUS :
                  state == PART_RD ? PCS_PARTNER_ABILITY : PCS_CONTROL;
      wdata     = state == CFG ? cfg_data : state == RESTART ? CTRL_AN_RESTART : 16'h0000;
      stat_link = rdata[STAT_LINK] & rdata[STAT_AN_DONE];
      // Losing the PHY never cuts an access short: leave only when the port is idle.
      drop      = state != WAIT_PHY && !phy_ready && (!active || done);
      cfg_end   = state == CFG && done && idx == CFG_LAST;
      rs_done   = state == RESTART && done;
      timeout   = cfg_done && !link_up && ld_cnt == LD_MAX;
      next      = state;
      case (state)
         WAIT_PHY:  next = phy_ready ? CFG : WAIT_PHY;
         CFG:       next = cfg_end ? POLL_WAIT : CFG;
         POLL_WAIT: next = poll_cnt == POLL_MAX ? (pend ? RESTART : STAT_RD) : POLL_WAIT;
         STAT_RD:   next = done ? (stat_link && !link_up ? PART_RD : POLL_WAIT) : STAT_RD;
         PART_RD:   next = done ? POLL_WAIT : PART_RD;
         RESTART:   next = done ? POLL_WAIT : RESTART;
         default:   next = WAIT_PHY;
      endcase
      if (drop)
         next = WAIT_PHY;
      rs_enter  = next == RESTART && state != RESTART;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= WAIT_PHY;
      else
         state <= next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx             <= '0;
         poll_cnt        <= '0;
         ld_cnt          <= '0;
         pend            <= 1'b0;
         cfg_done        <= 1'b0;
         link_up         <= 1'b0;
         partner_ability <= '0;
         restart_cnt     <= '0;
      end else begin
         idx      <= state == CFG ? idx + {2'b0, done} : 3'd0;
         poll_cnt <= state == POLL_WAIT && next == POLL_WAIT ? poll_cnt + 1'b1 : '0;
         if (!cfg_done || link_up || drop || rs_done)
            ld_cnt <= '0;
         else if (ld_cnt != LD_MAX)
            ld_cnt <= ld_cnt + 1'b1;
         // The timeout is masked while the restart write is in flight so that the
         // still-terminal counter cannot queue a second restart.
         if (drop || rs_enter)
            pend <= 1'b0;
         else if ((cfg_done && an_restart_req) || (timeout && state != RESTART))
            pend <= 1'b1;
         if (drop)
            cfg_done <= 1'b0;
         else if (cfg_end)
            cfg_done <= 1'b1;
         if (drop)
            link_up <= 1'b0;
         else if (state == STAT_RD && done)
            link_up <= stat_link;
         if (state == PART_RD && done)
            partner_ability <= rdata;
         if (rs_done && restart_cnt != 8'hFF)
            restart_cnt <= restart_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_tse_pcs_ctrl.sv
// tb_tse_pcs_ctrl: directed bench with an Avalon slave model and an access monitor
// that logs completed transfers and flags protocol violations.
module tb_tse_pcs_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        phy_ready = 1'b0;
   logic        an_restart_req = 1'b0;
   logic [4:0]  reg_addr;
   logic        reg_rd, reg_wr;
   logic [15:0] reg_data_in;
   logic [15:0] reg_data_out;
   logic        reg_busy;
   logic        cfg_done, link_up;
   logic [15:0] partner_ability;
   logic [7:0]  restart_cnt;

   logic [15:0] stat_val = 16'h0024;
   logic [15:0] part_val = 16'h41A0;
   int          busy_n = 0;
   logic        hold = 1'b0;
   int          wcnt = 0;
   logic        strobe;

   int passed = 0, failed = 0, total = 0;
   int cyc = 0, both_err = 0, b2b_err = 0, unstable_err = 0;
   int rs_count = 0, last_rs = -1, min_iv = 1000000, max_iv = 0;
   logic        prev_done = 1'b0, prev_held = 1'b0;
   logic [21:0] prev_req = '0;
   logic [21:0] log_q[$];

   tse_pcs_ctrl #(
      .POLL_PERIOD  (20),
      .LINK_TIMEOUT (200)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .phy_ready       (phy_ready),
      .an_restart_req  (an_restart_req),
      .reg_addr        (reg_addr),
      .reg_rd          (reg_rd),
      .reg_wr          (reg_wr),
      .reg_data_in     (reg_data_in),
      .reg_data_out    (reg_data_out),
      .reg_busy        (reg_busy),
      .cfg_done        (cfg_done),
      .link_up         (link_up),
      .partner_ability (partner_ability),
      .restart_cnt     (restart_cnt)
   );

   always #5 clk = ~clk;

   assign strobe       = reg_rd | reg_wr;
   assign reg_busy     = strobe && (hold || wcnt < busy_n);
   assign reg_data_out = reg_addr == 5'h01 ? stat_val : reg_addr == 5'h05 ? part_val : 16'hDEAD;

   always @(posedge clk) begin
      if (reg_rd && reg_wr) both_err++;
      if (prev_done && strobe) b2b_err++;
      if (prev_held && (strobe !== 1'b1 || {reg_wr, reg_addr, reg_data_in} !== prev_req)) unstable_err++;
      if (strobe && !reg_busy) begin
         log_q.push_back({reg_wr, reg_addr, reg_wr ? reg_data_in : reg_data_out});
         if (reg_wr && reg_addr == 5'h00) begin
            rs_count++;
            if (last_rs >= 0) begin
               if (cyc - last_rs < min_iv) min_iv = cyc - last_rs;
               if (cyc - last_rs > max_iv) max_iv = cyc - last_rs;
            end
            last_rs = cyc;
         end
      end
      prev_done = strobe && !reg_busy;
      prev_held = strobe && reg_busy;
      prev_req  = {reg_wr, reg_addr, reg_data_in};
      cyc++;
      wcnt <= (strobe && reg_busy) ? wcnt + 1 : 0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int count_of(input logic [21:0] e);
      int c = 0;
      foreach (log_q[i]) if (log_q[i] === e) c++;
      return c;
   endfunction

   logic [21:0] exp_cfg [5] = '{
      {1'b1, 5'h14, 16'h0000},
      {1'b1, 5'h04, 16'h01A0},
      {1'b1, 5'h12, 16'h12D0},
      {1'b1, 5'h13, 16'h0013},
      {1'b1, 5'h00, 16'h1340}
   };

   initial begin
      int n, fs, rs0;
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_cfg_done", cfg_done, 0);
      check("rst_link_up", link_up, 0);
      check("rst_partner", partner_ability, 0);
      check("rst_restart_cnt", restart_cnt, 0);
      check("rst_strobes", {reg_rd, reg_wr}, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("wait_phy_idle", strobe, 0);

      // Configuration sequence with no waitrequest
      phy_ready = 1'b1;
      n = 0; fs = -1;
      while (!cfg_done && n < 300) begin
         @(negedge clk); n++;
         if (fs < 0 && strobe) fs = n;
      end
      check("cfg_done_fast", cfg_done, 1);
      check("cfg_time_fast", n - fs, 9);
      check("cfg_len_fast", log_q.size(), 5);
      for (int i = 0; i < 5; i++) check($sformatf("cfg_fast_%0d", i), log_q[i], exp_cfg[i]);

      // Status read brings link up, partner read follows once
      n = 0;
      while (!(reg_rd && reg_addr == 5'h01 && !reg_busy) && n < 100) begin @(negedge clk); n++; end
      check("stat_rd_seen", reg_rd && reg_addr == 5'h01, 1);
      check("link_up_before", link_up, 0);
      @(negedge clk);
      check("link_up_after", link_up, 1);
      n = 0;
      while (partner_ability !== 16'h41A0 && n < 20) begin @(negedge clk); n++; end
      check("partner_ability", partner_ability, 16'h41A0);
      repeat (100) @(negedge clk);
      check("partner_rd_once", count_of({1'b0, 5'h05, 16'h41A0}), 1);
      check("no_restart_link_up", restart_cnt, 0);
      check("link_held", link_up, 1);

      // Manual AN restart while link is up
      log_q.delete();
      an_restart_req = 1'b1;
      @(negedge clk);
      an_restart_req = 1'b0;
      repeat (60) @(negedge clk);
      check("req_restart_cnt", restart_cnt, 1);
      check("req_restart_writes", count_of({1'b1, 5'h00, 16'h1340}), 1);

      // PHY drop while a status read is held busy
      hold = 1'b1;
      n = 0;
      while (!(reg_rd && reg_addr == 5'h01) && n < 100) begin @(negedge clk); n++; end
      check("held_rd_seen", reg_rd && reg_addr == 5'h01, 1);
      phy_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("held_rd_kept", {reg_rd, reg_addr}, {1'b1, 5'h01});
      check("held_cfg_done", cfg_done, 1);
      hold = 1'b0;
      repeat (2) @(negedge clk);
      check("drop_cfg_done", cfg_done, 0);
      check("drop_link_up", link_up, 0);
      check("drop_strobe", strobe, 0);
      check("drop_partner_kept", partner_ability, 16'h41A0);
      check("drop_restart_kept", restart_cnt, 1);
      check("drop_rd_completed", log_q[$], {1'b0, 5'h01, 16'h0024});
      an_restart_req = 1'b1;
      @(negedge clk);
      an_restart_req = 1'b0;
      repeat (4) @(negedge clk);

      // Replay with three waitrequest cycles per access
      busy_n = 3;
      log_q.delete();
      phy_ready = 1'b1;
      n = 0; fs = -1;
      while (!cfg_done && n < 400) begin
         @(negedge clk); n++;
         if (fs < 0 && strobe) fs = n;
      end
      check("cfg_done_busy", cfg_done, 1);
      check("cfg_time_busy", n - fs, 24);
      check("cfg_len_busy", log_q.size(), 5);
      for (int i = 0; i < 5; i++) check($sformatf("cfg_busy_%0d", i), log_q[i], exp_cfg[i]);
      n = 0;
      while (!link_up && n < 300) begin @(negedge clk); n++; end
      check("relink", link_up, 1);
      check("early_req_ignored", restart_cnt, 1);

      // Link lost: periodic restarts and saturation
      busy_n = 0;
      stat_val = 16'h0004;
      n = 0;
      while (link_up && n < 100) begin @(negedge clk); n++; end
      check("link_lost", link_up, 0);
      last_rs = -1; min_iv = 1000000; max_iv = 0;
      n = 0;
      while (restart_cnt != 8'hFF && n < 70000) begin @(negedge clk); n++; end
      check("restart_sat_reached", restart_cnt, 8'hFF);
      rs0 = rs_count;
      repeat (600) @(negedge clk);
      check("restart_sat_held", restart_cnt, 8'hFF);
      check("restarts_continue", (rs_count - rs0) >= 2, 1);
      check("restart_iv_min", min_iv >= 200, 1);
      check("restart_iv_max", max_iv <= 230, 1);

      check("both_strobes", both_err, 0);
      check("back_to_back", b2b_err, 0);
      check("unstable_hold", unstable_err, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
